// File: rtl/pipeline_flow_controller_pkg.sv
// Shared state encodings, stage-control bundle and default timing constants
// for the pipeline flow controller.
package pipeline_flow_controller_pkg;

  typedef enum logic [1:0] {
    PFC_S_RUN      = 2'd0,
    PFC_S_MEM_WAIT = 2'd1,
    PFC_S_DRAIN    = 2'd2,
    PFC_S_HALTED   = 2'd3
  } pfc_state_e;

  localparam int unsigned PFC_MEM_TIMEOUT  = 16;
  localparam int unsigned PFC_DRAIN_CYCLES = 3;
  localparam int unsigned PFC_CNT_WIDTH    = 32;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_we;
  } pfc_ctrl_t;

  localparam pfc_ctrl_t PFC_FREEZE     = pfc_ctrl_t'(7'b000_0000);
  localparam pfc_ctrl_t PFC_ADVANCE    = pfc_ctrl_t'(7'b110_1011);
  localparam pfc_ctrl_t PFC_BRANCH     = pfc_ctrl_t'(7'b111_1111);
  localparam pfc_ctrl_t PFC_JUMP       = pfc_ctrl_t'(7'b111_1011);
  localparam pfc_ctrl_t PFC_LOAD_USE   = pfc_ctrl_t'(7'b000_1111);
  localparam pfc_ctrl_t PFC_HALT_ENTRY = pfc_ctrl_t'(7'b011_1011);
  localparam pfc_ctrl_t PFC_DRAIN      = pfc_ctrl_t'(7'b011_1111);
  // While reset is held every register is frozen and both front-end latches load NOPs.
  localparam pfc_ctrl_t PFC_RESET      = pfc_ctrl_t'(7'b001_0100);

endpackage

// File: rtl/pfc_sat_counter.sv
// Enable-driven up-counter that sticks at all-ones instead of wrapping.
module pfc_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_flow_controller.sv
// Central stall/flush/halt sequencer for the five-stage core_lapido pipeline.
//
// state          | meaning
// PFC_S_RUN      | normal issue; hazards, jumps, branches and halt entry resolved here
// PFC_S_MEM_WAIT | pipe frozen waiting for data-memory ready, bounded by MEM_TIMEOUT
// PFC_S_DRAIN    | fetch stopped, back end drains for DRAIN_CYCLES advancing cycles
// PFC_S_HALTED   | core stopped; only reset leaves this state
module pipeline_flow_controller
  import pipeline_flow_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = PFC_MEM_TIMEOUT,
  parameter int unsigned DRAIN_CYCLES = PFC_DRAIN_CYCLES,
  parameter int unsigned CNT_WIDTH    = PFC_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_use_hazard,
  input  logic                 is_jump,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  input  logic                 halt_req,
  output logic                 pc_write_enable,
  output logic                 if_id_write_enable,
  output logic                 if_id_flush,
  output logic                 id_ex_write_enable,
  output logic                 id_ex_flush,
  output logic                 ex_mem_write_enable,
  output logic                 mem_wb_write_enable,
  output logic                 halted,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  pfc_state_e        state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [WAIT_W:0]    wait_inc;
  logic [DRAIN_W:0]   drain_inc;
  logic               timeout_q, timeout_d;
  logic               mem_block;
  logic               stall_inc, flush_inc;
  pfc_ctrl_t          ctrl;

  assign mem_block = mem_req && !mem_ready;
  // One extra bit so the terminal compare still works for tiny parameter values.
  assign wait_inc  = {1'b0, wait_q} + (WAIT_W + 1)'(1);
  assign drain_inc = {1'b0, drain_q} + (DRAIN_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    drain_d   = drain_q;
    timeout_d = timeout_q;
    ctrl      = PFC_FREEZE;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      PFC_S_RUN: begin
        if (mem_block) begin
          stall_inc = 1'b1;
          wait_d    = WAIT_W'(1);
          state_d   = PFC_S_MEM_WAIT;
        end else if (branch_taken) begin
          ctrl      = PFC_BRANCH;
          flush_inc = 1'b1;
        end else if (is_jump) begin
          ctrl      = PFC_JUMP;
          flush_inc = 1'b1;
        end else if (load_use_hazard) begin
          ctrl      = PFC_LOAD_USE;
          stall_inc = 1'b1;
        end else if (halt_req) begin
          ctrl      = PFC_HALT_ENTRY;
          stall_inc = 1'b1;
          drain_d   = DRAIN_W'(1);
          state_d   = PFC_S_DRAIN;
        end else begin
          ctrl = PFC_ADVANCE;
        end
      end
      PFC_S_MEM_WAIT: begin
        if (mem_ready) begin
          ctrl    = PFC_ADVANCE;
          state_d = PFC_S_RUN;
        end else begin
          stall_inc = 1'b1;
          wait_d    = wait_inc[WAIT_W-1:0];
          if (wait_inc >= (WAIT_W + 1)'(MEM_TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = PFC_S_HALTED;
          end
        end
      end
      PFC_S_DRAIN: begin
        if (!mem_block) begin
          ctrl    = PFC_DRAIN;
          drain_d = drain_inc[DRAIN_W-1:0];
          if (drain_inc >= (DRAIN_W + 1)'(DRAIN_CYCLES)) begin
            state_d = PFC_S_HALTED;
          end
        end
      end
      PFC_S_HALTED: begin
        ctrl = PFC_FREEZE;
      end
      default: begin
        state_d = PFC_S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PFC_S_RUN;
      wait_q    <= '0;
      drain_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      timeout_q <= timeout_d;
    end
  end

  pfc_ctrl_t ctrl_out;
  assign ctrl_out = rst ? ctrl : PFC_RESET;

  assign pc_write_enable     = ctrl_out.pc_we;
  assign if_id_write_enable  = ctrl_out.if_id_we;
  assign if_id_flush         = ctrl_out.if_id_flush;
  assign id_ex_write_enable  = ctrl_out.id_ex_we;
  assign id_ex_flush         = ctrl_out.id_ex_flush;
  assign ex_mem_write_enable = ctrl_out.ex_mem_we;
  assign mem_wb_write_enable = ctrl_out.mem_wb_we;
  assign halted              = rst && (state_q == PFC_S_HALTED);
  assign mem_timeout         = timeout_q;

  pfc_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (stall_inc),
    .count_o (stall_count)
  );

  pfc_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (flush_inc),
    .count_o (flush_count)
  );

endmodule

// File: tb/tb_pipeline_flow_controller.sv
// Bench for pipeline_flow_controller: hand table, corner sequences and a
// randomized run against a rule-level model; a narrow-counter twin checks saturation.
module tb_pipeline_flow_controller;

  localparam int MT  = 16;
  localparam int DC  = 3;
  localparam int CW  = 32;
  localparam int CWS = 3;

  localparam logic [6:0] O_RST = 7'b0010100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_use_hazard = 1'b0, is_jump = 1'b0, branch_taken = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;

  logic pc_a, ifwe_a, iffl_a, idwe_a, idfl_a, exwe_a, mwwe_a, halted_a, tout_a;
  logic [CW-1:0] stall_a, flush_a;
  logic pc_b, ifwe_b, iffl_b, idwe_b, idfl_b, exwe_b, mwwe_b, halted_b, tout_b;
  logic [CWS-1:0] stall_b, flush_b;

  always #5 clk = ~clk;

  pipeline_flow_controller #(.MEM_TIMEOUT(MT), .DRAIN_CYCLES(DC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .is_jump(is_jump),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_write_enable(pc_a), .if_id_write_enable(ifwe_a), .if_id_flush(iffl_a),
    .id_ex_write_enable(idwe_a), .id_ex_flush(idfl_a), .ex_mem_write_enable(exwe_a),
    .mem_wb_write_enable(mwwe_a), .halted(halted_a), .mem_timeout(tout_a),
    .stall_count(stall_a), .flush_count(flush_a));

  pipeline_flow_controller #(.MEM_TIMEOUT(MT), .DRAIN_CYCLES(DC), .CNT_WIDTH(CWS)) dut_s (
    .clk(clk), .rst(rst), .load_use_hazard(load_use_hazard), .is_jump(is_jump),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_write_enable(pc_b), .if_id_write_enable(ifwe_b), .if_id_flush(iffl_b),
    .id_ex_write_enable(idwe_b), .id_ex_flush(idfl_b), .ex_mem_write_enable(exwe_b),
    .mem_wb_write_enable(mwwe_b), .halted(halted_b), .mem_timeout(tout_b),
    .stall_count(stall_b), .flush_count(flush_b));

  int total = 0;
  int bad   = 0;

  // Rule-level model: counts of cycles rather than named states.
  int     m_wait;   // consecutive frozen memory cycles so far, 0 when not waiting
  int     m_drain;  // fetch-stopped advancing cycles so far, 0 when not draining
  bit     m_halt, m_tout;
  longint m_stall, m_flush;

  typedef struct {
    logic [5:0] stim;   // {lu, jump, branch, mem_req, mem_ready, halt}
    logic [6:0] out;    // {pc, ifwe, iffl, idwe, idfl, exwe, mwwe}
    logic       hlt;
    int         stall;
    int         flsh;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [6:0] pack_a();
    return {pc_a, ifwe_a, iffl_a, idwe_a, idfl_a, exwe_a, mwwe_a};
  endfunction

  function automatic logic [6:0] pack_b();
    return {pc_b, ifwe_b, iffl_b, idwe_b, idfl_b, exwe_b, mwwe_b};
  endfunction

  function automatic logic [63:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_drain = 0; m_halt = 0; m_tout = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic logic [6:0] model_out();
    bit blk;
    blk = mem_req && !mem_ready;
    if (!rst)        return O_RST;
    if (m_halt)      return 7'b0000000;
    if (m_wait > 0)  return mem_ready ? 7'b1101011 : 7'b0000000;
    if (m_drain > 0) return blk ? 7'b0000000 : 7'b0111111;
    if (blk)             return 7'b0000000;
    if (branch_taken)    return 7'b1111111;
    if (is_jump)         return 7'b1111011;
    if (load_use_hazard) return 7'b0001111;
    if (halt_req)        return 7'b0111011;
    return 7'b1101011;
  endfunction

  task automatic model_step();
    bit blk;
    blk = mem_req && !mem_ready;
    if (!rst) begin
      model_reset();
    end else if (m_halt) begin
    end else if (m_wait > 0) begin
      if (mem_ready) m_wait = 0;
      else begin
        m_stall++;
        m_wait++;
        if (m_wait >= MT) begin m_halt = 1; m_tout = 1; m_wait = 0; end
      end
    end else if (m_drain > 0) begin
      if (!blk) begin
        m_drain++;
        if (m_drain >= DC) begin m_halt = 1; m_drain = 0; end
      end
    end else if (blk) begin
      m_stall++; m_wait = 1;
    end else if (branch_taken || is_jump) begin
      m_flush++;
    end else if (load_use_hazard) begin
      m_stall++;
    end else if (halt_req) begin
      m_stall++; m_drain = 1;
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, ".stall"},   stall_a, sat(m_stall, CW));
    chk({tag, ".flush"},   flush_a, sat(m_flush, CW));
    chk({tag, ".stall_s"}, stall_b, sat(m_stall, CWS));
    chk({tag, ".flush_s"}, flush_b, sat(m_flush, CWS));
  endtask

  // Entered at posedge+1 with inputs applied; leaves at the next posedge+1.
  task automatic cycle_check(input string tag);
    @(negedge clk);
    chk({tag, ".out"},   pack_a(), model_out());
    chk({tag, ".out_s"}, pack_b(), model_out());
    chk({tag, ".halted"}, halted_a, m_halt);
    chk({tag, ".tout"},   tout_a, m_tout);
    @(posedge clk); #1;
    model_step();
    check_counters(tag);
  endtask

  task automatic set_in(input logic [5:0] v);
    {load_use_hazard, is_jump, branch_taken, mem_req, mem_ready, halt_req} = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    set_in(6'($urandom));
    @(negedge clk);
    chk("rst.out",    pack_a(), O_RST);
    chk("rst.out_s",  pack_b(), O_RST);
    chk("rst.halted", halted_a, 1'b0);
    chk("rst.tout",   tout_a, 1'b0);
    check_counters("rst");
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(6'b000000);
  endtask

  initial begin
    bit hold_halt;
    bit slow;

    tbl[0]  = '{6'b000000, 7'b1101011, 1'b0, 0, 0};
    tbl[1]  = '{6'b100000, 7'b0001111, 1'b0, 1, 0};
    tbl[2]  = '{6'b111000, 7'b1111111, 1'b0, 1, 1};
    tbl[3]  = '{6'b010000, 7'b1111011, 1'b0, 1, 2};
    tbl[4]  = '{6'b110000, 7'b1111011, 1'b0, 1, 3};
    tbl[5]  = '{6'b100110, 7'b0001111, 1'b0, 2, 3};
    tbl[6]  = '{6'b100001, 7'b0001111, 1'b0, 3, 3};
    tbl[7]  = '{6'b001001, 7'b1111111, 1'b0, 3, 4};
    tbl[8]  = '{6'b001101, 7'b0000000, 1'b0, 4, 4};
    tbl[9]  = '{6'b001100, 7'b0000000, 1'b0, 5, 4};
    tbl[10] = '{6'b101110, 7'b1101011, 1'b0, 5, 4};
    tbl[11] = '{6'b001000, 7'b1111111, 1'b0, 5, 5};
    tbl[12] = '{6'b000001, 7'b0111011, 1'b0, 6, 5};
    tbl[13] = '{6'b011001, 7'b0111111, 1'b0, 6, 5};
    tbl[14] = '{6'b000101, 7'b0000000, 1'b0, 6, 5};
    tbl[15] = '{6'b000001, 7'b0111111, 1'b0, 6, 5};
    tbl[16] = '{6'b000001, 7'b0000000, 1'b1, 6, 5};
    tbl[17] = '{6'b111101, 7'b0000000, 1'b1, 6, 5};

    #1;
    do_reset();
    for (int i = 0; i < 5; i++) cycle_check("idle");

    for (int k = 0; k < 18; k++) begin
      set_in(tbl[k].stim);
      @(negedge clk);
      chk($sformatf("vec%0d.out", k),    pack_a(), tbl[k].out);
      chk($sformatf("vec%0d.halted", k), halted_a, tbl[k].hlt);
      chk($sformatf("vec%0d.tout", k),   tout_a, 1'b0);
      @(posedge clk); #1;
      model_step();
      chk($sformatf("vec%0d.stall", k), stall_a, 64'(tbl[k].stall));
      chk($sformatf("vec%0d.flush", k), flush_a, 64'(tbl[k].flsh));
    end

    // Four frozen memory cycles then ready.
    do_reset();
    set_in(6'b000100);
    for (int i = 0; i < 4; i++) cycle_check("mwait");
    set_in(6'b000110);
    cycle_check("mready");
    chk("mwait.stall4", stall_a, 64'd4);
    set_in(6'b000000);
    cycle_check("mwait.after");

    // Memory never answers: fatal timeout, then reset clears it.
    do_reset();
    set_in(6'b000100);
    for (int i = 0; i < MT; i++) begin
      cycle_check("tmo");
      if (i == MT - 2) chk("tmo.not_yet", halted_a, 1'b0);
    end
    chk("tmo.halted", halted_a, 1'b1);
    chk("tmo.flag",   tout_a, 1'b1);
    chk("tmo.stall",  stall_a, 64'(MT));
    set_in(6'b000110);
    cycle_check("tmo.hold");
    do_reset();
    cycle_check("tmo.rerun");

    // Reset in the middle of a memory wait and of a drain.
    set_in(6'b000100);
    for (int i = 0; i < 3; i++) cycle_check("mid_wait");
    do_reset();
    cycle_check("mid_wait.run");
    set_in(6'b000001);
    for (int i = 0; i < 2; i++) cycle_check("mid_drain");
    do_reset();
    cycle_check("mid_drain.run");

    hold_halt = 0;
    slow = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) slow = ($urandom_range(0, 3) == 0);
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) begin
        do_reset();
        hold_halt = 0;
      end else begin
        load_use_hazard = ($urandom_range(0, 4) == 0);
        is_jump         = ($urandom_range(0, 9) == 0);
        branch_taken    = ($urandom_range(0, 9) == 0);
        mem_req         = ($urandom_range(0, 2) == 0) || (m_wait > 0);
        mem_ready       = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 0);
        if (!hold_halt && $urandom_range(0, 39) == 0) hold_halt = 1;
        halt_req        = hold_halt;
        cycle_check("rand");
        if (m_halt) hold_halt = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_flow_controller.md
Name: pipeline_flow_controller

Overview:
- Central sequencer for the five-stage core_lapido pipeline.
- Merges the hazard_detection_unit load-use request, the ID-stage jump, the EX-stage branch decision, a data-memory ready handshake and an external halt request.
- Produces per-stage write enables and flushes, plus a halt/drain sequence.
- Keeps saturating stall and flush counters for bring-up benches.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles without mem_ready before the fatal timeout
DRAIN_CYCLES, 3, cycles spent draining ID/EX, EX/MEM and MEM/WB after a halt request
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
load_use_hazard  in  1  stall request from hazard_detection_unit, same cycle
is_jump  in  1  J/JAL/JR decoded in ID, same cycle
branch_taken  in  1  branch resolved taken in EX, same cycle
mem_req  in  1  MEM stage holds a load/store
mem_ready  in  1  data memory completes the access this cycle
halt_req  in  1  request to stop fetching and drain
pc_write_enable  out  1  PC register update
if_id_write_enable  out  1  IF/ID register update
if_id_flush  out  1  load NOP into IF/ID
id_ex_write_enable  out  1  ID/EX register update
id_ex_flush  out  1  load bubble (all controls 0) into ID/EX
ex_mem_write_enable  out  1  EX/MEM register update
mem_wb_write_enable  out  1  MEM/WB register update
halted  out  1  core stopped
mem_timeout  out  1  sticky fatal error
stall_count  out  CNT_WIDTH  stall cycles seen
flush_count  out  CNT_WIDTH  flush events seen

Behaviour:
- FSM states: S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED. Encodings are 2 bits. Outputs are combinational from state and inputs. State and counters are registered.
- While rst=0: state=S_RUN, all counters=0, mem_timeout=0, all write enables=0, if_id_flush=id_ex_flush=1, halted=0. Reset mid-sequence, in any state, takes effect immediately.
- Freeze means all five enables=0 and both flushes=0.
- S_RUN priority, highest first:
  (1) mem_req&&!mem_ready: freeze; next state S_MEM_WAIT; wait counter := 1.
  (2) branch_taken: all enables=1; if_id_flush=1; id_ex_flush=1.
  (3) is_jump: all enables=1; if_id_flush=1.
  (4) load_use_hazard: pc_write_enable=0; if_id_write_enable=0; id_ex_flush=1; others 1.
  (5) halt_req: pc_write_enable=0; if_id_flush=1; others 1; next state S_DRAIN; drain counter := 1.
  (6) Otherwise: all enables=1, no flush.
- A halt_req that coincides with a higher-priority event is ignored that cycle. The requester holds halt_req until halted.
- S_MEM_WAIT:
  - mem_ready=1: all enables=1, no flush; next state S_RUN. Branch, jump and load-use are not evaluated this cycle; the frozen IF/ID and ID/EX contents re-present them next cycle.
  - mem_ready=0: freeze; wait counter increments. When the counter reaches MEM_TIMEOUT, set mem_timeout and go to S_HALTED.
- S_DRAIN:
  - pc_write_enable=0, if_id_flush=1, id_ex_flush=1. ID/EX, EX/MEM and MEM/WB write enables=1. branch_taken and is_jump are ignored.
  - mem_req&&!mem_ready freezes the pipe without advancing the drain counter.
  - Drain counter reaching DRAIN_CYCLES and advancing goes to S_HALTED.
- S_HALTED: all enables=0, flushes=0, halted=1. Only reset exits.
- stall_count: +1 each cycle in S_RUN or S_MEM_WAIT where pc_write_enable=0.
- flush_count: +1 each S_RUN cycle where case (2) or (3) applies.
- Both counters saturate at all-ones and never wrap.
- Internal wait and drain counters are $clog2(MEM_TIMEOUT+1) and $clog2(DRAIN_CYCLES+1) bits wide.

Decomposition:
- lapido_defs.v gains PFC_S_RUN/PFC_S_MEM_WAIT/PFC_S_DRAIN/PFC_S_HALTED encodings and the default MEM_TIMEOUT/DRAIN_CYCLES constants.
- One sub-module, pfc_sat_counter (enable-driven saturating counter, async active-low clear), instantiated for stall_count and flush_count.

Test Plan:
- Reset then idle 5 cycles, no requests -> all enables=1, flushes=0, stall_count=0, flush_count=0.
- Pulse load_use_hazard for 1 cycle -> that cycle pc_write_enable=0, if_id_write_enable=0, id_ex_flush=1; stall_count=1.
- branch_taken with is_jump and load_use_hazard in the same cycle -> if_id_flush=1, id_ex_flush=1, all enables=1; flush_count=1, stall_count=0.
- mem_req=1, mem_ready low 4 cycles then high -> freeze 4 cycles, enables=1 on the 5th, back to S_RUN; stall_count=4.
- mem_req=1, mem_ready=0 for 16 cycles -> mem_timeout=1, halted=1 from the next cycle. Deassert rst -> mem_timeout=0, state S_RUN.
- halt_req held -> pc_write_enable=0 for 3 drain cycles with downstream enables=1; then halted=1. A mem stall inserted mid-drain extends the drain by its length.
